// File: rtl/left_io_tile_gen.sv
// rtl/left_io_tile_gen.sv - left-edge I/O tile: switch block, pad connection block, counted ccff scan chain
// Optional macro LEFT_IO_TILE_SHADOW_EN routes from a commit-loaded shadow copy of the chain.
module left_io_tile_gen #(
   parameter int CHAN_W = 30,
   parameter int N_IO   = 4,
   parameter int N_OPIN = 8
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              ccff_head,
   input  logic              ccff_en,
   input  logic              ccff_commit,
   output logic              ccff_tail,
   output logic              cfg_done,
   input  logic              isol_n,
   input  logic [CHAN_W-1:0] chany_top_in,
   input  logic [CHAN_W-1:0] chany_bottom_in,
   input  logic [CHAN_W-1:0] chanx_right_in,
   output logic [CHAN_W-1:0] chany_top_out,
   output logic [CHAN_W-1:0] chany_bottom_out,
   output logic [CHAN_W-1:0] chanx_right_out,
   input  logic [N_OPIN-1:0] right_opin,
   input  logic [N_IO-1:0]   gfpga_pad_io_soc_in,
   output logic [N_IO-1:0]   gfpga_pad_io_soc_out,
   output logic [N_IO-1:0]   gfpga_pad_io_soc_dir,
   output logic [N_IO-1:0]   inpad
);
   localparam int CHAIN_LEN = 6*CHAN_W + N_IO;
   localparam int CNT_W     = $clog2(CHAIN_LEN+1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

   logic [CHAIN_LEN-1:0] chain;
   logic [CHAIN_LEN-1:0] act;
   logic [CNT_W-1:0]     bit_cnt;
   logic [N_IO-1:0]      d;

   // bit_cnt saturates so cfg_done stays high through any over-shift
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset) begin
         chain   <= '0;
         bit_cnt <= '0;
      end else if (ccff_en) begin
         chain <= {chain[CHAIN_LEN-2:0], ccff_head};
         if (bit_cnt != CNT_MAX)
            bit_cnt <= bit_cnt + 1'b1;
      end
   end

   assign ccff_tail = chain[CHAIN_LEN-1];
   assign cfg_done  = (bit_cnt == CNT_MAX);

`ifdef LEFT_IO_TILE_SHADOW_EN
   logic [CHAIN_LEN-1:0] shadow;

   // commit samples the pre-shift chain even when a shift happens on the same edge
   always_ff @(posedge prog_clk or posedge prog_reset) begin
      if (prog_reset)
         shadow <= '0;
      else if (ccff_commit)
         shadow <= chain;
   end

   assign act = shadow;
`else
   logic unused_commit;
   assign unused_commit = ccff_commit;
   assign act = chain;
`endif

   assign d                    = act[6*CHAN_W +: N_IO];
   assign gfpga_pad_io_soc_dir = ~d | {N_IO{~isol_n}};
   assign gfpga_pad_io_soc_out = chany_bottom_in[N_IO-1:0] & d & {N_IO{isol_n}};
   assign inpad                = gfpga_pad_io_soc_in & ~d & {N_IO{isol_n}};

   always_comb begin
      chany_top_out    = '0;
      chany_bottom_out = '0;
      chanx_right_out  = '0;
      for (int i = 0; i < CHAN_W; i++) begin
         case (act[2*i +: 2])
            2'd0:    chany_top_out[i] = chany_bottom_in[i];
            2'd1:    chany_top_out[i] = chanx_right_in[i];
            2'd2:    chany_top_out[i] = inpad[i % N_IO];
            default: chany_top_out[i] = 1'b0;
         endcase
         case (act[2*CHAN_W + 2*i +: 2])
            2'd0:    chany_bottom_out[i] = chany_top_in[i];
            2'd1:    chany_bottom_out[i] = chanx_right_in[i];
            2'd2:    chany_bottom_out[i] = inpad[i % N_IO];
            default: chany_bottom_out[i] = 1'b0;
         endcase
         case (act[4*CHAN_W + 2*i +: 2])
            2'd0:    chanx_right_out[i] = chany_bottom_in[i];
            2'd1:    chanx_right_out[i] = chany_top_in[i];
            2'd2:    chanx_right_out[i] = right_opin[i % N_OPIN];
            default: chanx_right_out[i] = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_left_io_tile_gen.sv
// tb/tb_left_io_tile_gen.sv - randomized self-checking bench for left_io_tile_gen
// Honours LEFT_IO_TILE_SHADOW_EN to match the design build.
module tb_left_io_tile_gen;
   localparam int W   = 30;
   localparam int NIO = 4;
   localparam int NOP = 8;
   localparam int CL  = 6*W + NIO;
   localparam int OW  = 3*W + 3*NIO + 2;

   logic           prog_clk = 1'b0;
   logic           prog_reset;
   logic           ccff_head, ccff_en, ccff_commit;
   logic           ccff_tail, cfg_done;
   logic           isol_n;
   logic [W-1:0]   chany_top_in, chany_bottom_in, chanx_right_in;
   logic [W-1:0]   chany_top_out, chany_bottom_out, chanx_right_out;
   logic [NOP-1:0] right_opin;
   logic [NIO-1:0] pad_in, pad_out, pad_dir, inpad;
   logic [OW-1:0]  obs;

   int n_checks = 0;
   int n_pass   = 0;

   // reference state: most recent enabled head bits, newest first
   logic           hist[$];
   int             n_shift;
   logic [CL-1:0]  m_shadow;

   always #5 prog_clk = ~prog_clk;

   left_io_tile_gen #(.CHAN_W(W), .N_IO(NIO), .N_OPIN(NOP)) dut (
      .prog_clk(prog_clk), .prog_reset(prog_reset),
      .ccff_head(ccff_head), .ccff_en(ccff_en), .ccff_commit(ccff_commit),
      .ccff_tail(ccff_tail), .cfg_done(cfg_done), .isol_n(isol_n),
      .chany_top_in(chany_top_in), .chany_bottom_in(chany_bottom_in), .chanx_right_in(chanx_right_in),
      .chany_top_out(chany_top_out), .chany_bottom_out(chany_bottom_out), .chanx_right_out(chanx_right_out),
      .right_opin(right_opin), .gfpga_pad_io_soc_in(pad_in), .gfpga_pad_io_soc_out(pad_out),
      .gfpga_pad_io_soc_dir(pad_dir), .inpad(inpad)
   );

   assign obs = {chany_top_out, chany_bottom_out, chanx_right_out, pad_dir, pad_out, inpad, cfg_done, ccff_tail};

   function automatic logic [CL-1:0] chain_vec();
      logic [CL-1:0] v = '0;
      for (int j = 0; j < hist.size(); j++) v[j] = hist[j];
      return v;
   endfunction

   function automatic logic [CL-1:0] act_vec();
`ifdef LEFT_IO_TILE_SHADOW_EN
      return m_shadow;
`else
      return chain_vec();
`endif
   endfunction

   function automatic logic [OW-1:0] model_out();
      logic [CL-1:0]  a;
      logic [W-1:0]   t, b, r;
      logic [NIO-1:0] dir, o, ip;
      logic           dk, tail;
      int             s;
      a = act_vec();
      for (int k = 0; k < NIO; k++) begin
         dk     = a[6*W + k];
         dir[k] = !dk || !isol_n;
         o[k]   = chany_bottom_in[k] && dk && isol_n;
         ip[k]  = pad_in[k] && !dk && isol_n;
      end
      for (int i = 0; i < W; i++) begin
         s = 2*int'(a[2*i+1]) + int'(a[2*i]);
         t[i] = (s == 0) ? chany_bottom_in[i] : (s == 1) ? chanx_right_in[i] : (s == 2) ? ip[i % NIO] : 1'b0;
         s = 2*int'(a[2*W+2*i+1]) + int'(a[2*W+2*i]);
         b[i] = (s == 0) ? chany_top_in[i] : (s == 1) ? chanx_right_in[i] : (s == 2) ? ip[i % NIO] : 1'b0;
         s = 2*int'(a[4*W+2*i+1]) + int'(a[4*W+2*i]);
         r[i] = (s == 0) ? chany_bottom_in[i] : (s == 1) ? chany_top_in[i] : (s == 2) ? right_opin[i % NOP] : 1'b0;
      end
      tail = (hist.size() == CL) ? hist[CL-1] : 1'b0;
      return {t, b, r, dir, o, ip, (n_shift >= CL), tail};
   endfunction

   task automatic model_clear();
      hist.delete();
      n_shift  = 0;
      m_shadow = '0;
   endtask

   task automatic rand_inputs();
      logic [31:0] r;
      r = $urandom; chany_top_in    = r[W-1:0];
      r = $urandom; chany_bottom_in = r[W-1:0];
      r = $urandom; chanx_right_in  = r[W-1:0];
      r = $urandom; right_opin      = r[NOP-1:0];
      r = $urandom; pad_in          = r[NIO-1:0];
      isol_n = ($urandom_range(0, 7) != 0);
   endtask

   // one clock edge; called and returns at posedge+1
   task automatic step(input logic en, input logic head, input logic commit);
      ccff_en = en; ccff_head = head; ccff_commit = commit;
      @(posedge prog_clk);
`ifdef LEFT_IO_TILE_SHADOW_EN
      if (commit) m_shadow = chain_vec();
`endif
      if (en) begin
         hist.push_front(head);
         if (hist.size() > CL) void'(hist.pop_back());
         n_shift++;
      end
      #1;
      ccff_en = 1'b0; ccff_commit = 1'b0;
   endtask

   task automatic do_reset();
      prog_reset = 1'b1;
      model_clear();
      repeat (2) @(posedge prog_clk);
      #1;
      prog_reset = 1'b0;
   endtask

   task automatic load_frame(input logic [CL-1:0] frame);
      for (int j = CL-1; j >= 0; j--) step(1'b1, frame[j], 1'b0);
`ifdef LEFT_IO_TILE_SHADOW_EN
      step(1'b0, 1'b0, 1'b1);
`endif
   endtask

   function automatic logic [CL-1:0] rand_frame();
      logic [CL-1:0] f;
      for (int j = 0; j < CL; j++) f[j] = 1'($urandom_range(0, 1));
      return f;
   endfunction

   task automatic test_reset();
      logic [OW-1:0] e;
      chany_top_in = '0; chanx_right_in = '0; right_opin = '0; pad_in = '0;
      chany_bottom_in = 30'h155; isol_n = 1'b1;
      prog_reset = 1'b1;
      model_clear();
      #1;
      n_checks++;
      if (chany_top_out !== 30'h155) $display("FAIL reset_top: got %h expected %h", chany_top_out, 30'h155);
      else n_pass++;
      n_checks++;
      if (pad_dir !== 4'hF) $display("FAIL reset_dir: got %h expected %h", pad_dir, 4'hF);
      else n_pass++;
      n_checks++;
      if (cfg_done !== 1'b0 || ccff_tail !== 1'b0 || pad_out !== 4'h0)
         $display("FAIL reset_flags: got done=%b tail=%b out=%h expected 0 0 0", cfg_done, ccff_tail, pad_out);
      else n_pass++;
      e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL reset_model: got %h expected %h", obs, e);
      else n_pass++;
      @(posedge prog_clk); #1;
      prog_reset = 1'b0;
   endtask

   task automatic test_chain_latency();
      do_reset();
      for (int e = 1; e <= 190; e++) begin
         step(1'b1, (e == 1), 1'b0);
         n_checks++;
         if (ccff_tail !== (e == CL) || cfg_done !== (e >= CL))
            $display("FAIL latency edge %0d: got tail=%b done=%b expected tail=%b done=%b",
                     e, ccff_tail, cfg_done, (e == CL), (e >= CL));
         else n_pass++;
      end
   endtask

   task automatic test_enable_gating();
      logic [OW-1:0] e;
      do_reset();
      for (int c = 0; c < 2*CL; c++) begin
         rand_inputs();
         step(1'(c % 2), 1'($urandom_range(0, 1)), 1'b0);
         e = model_out();
         n_checks++;
         if (obs !== e) $display("FAIL gating cycle %0d: got %h expected %h", c, obs, e);
         else n_pass++;
      end
      n_checks++;
      if (cfg_done !== 1'b1 || n_shift != CL)
         $display("FAIL gating_done: got done=%b shifts=%0d expected 1 %0d", cfg_done, n_shift, CL);
      else n_pass++;
   endtask

   task automatic test_mux_pad();
      logic [CL-1:0] f = '0;
      logic [OW-1:0] e;
      do_reset();
      f[1:0] = 2'd2;
      f[4*W+7 -: 2] = 2'd2;
      f[6*W] = 1'b0;
      rand_inputs();
      right_opin = 8'h08; pad_in = 4'h1; isol_n = 1'b1;
      load_frame(f);
      n_checks++;
      if (chany_top_out[0] !== 1'b1 || chanx_right_out[3] !== 1'b1)
         $display("FAIL mux_sel: got top0=%b right3=%b expected 1 1", chany_top_out[0], chanx_right_out[3]);
      else n_pass++;
      e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL mux_model: got %h expected %h", obs, e);
      else n_pass++;
      isol_n = 1'b0;
      #1;
      n_checks++;
      if (inpad !== 4'h0 || pad_dir !== 4'hF)
         $display("FAIL isolation: got inpad=%h dir=%h expected 0 f", inpad, pad_dir);
      else n_pass++;
      isol_n = 1'b1;
   endtask

   task automatic test_mid_frame_reset();
      logic [OW-1:0] e;
      do_reset();
      rand_inputs();
      isol_n = 1'b1;
      for (int j = 0; j < 100; j++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      prog_reset = 1'b1;
      model_clear();
      #2;
      n_checks++;
      if (cfg_done !== 1'b0 || ccff_tail !== 1'b0 || pad_dir !== 4'hF || pad_out !== 4'h0)
         $display("FAIL midreset_flags: got done=%b tail=%b dir=%h out=%h expected 0 0 f 0",
                  cfg_done, ccff_tail, pad_dir, pad_out);
      else n_pass++;
      e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL midreset_model: got %h expected %h", obs, e);
      else n_pass++;
      prog_reset = 1'b0;
      #2;
      @(posedge prog_clk); #1;
      load_frame(rand_frame());
      e = model_out();
      n_checks++;
      if (cfg_done !== 1'b1 || obs !== e) $display("FAIL midreset_reload: got %h expected %h", obs, e);
      else n_pass++;
   endtask

   task automatic test_random_routing();
      logic [OW-1:0] e;
      for (int f = 0; f < 4; f++) begin
         do_reset();
         load_frame(rand_frame());
         for (int v = 0; v < 6; v++) begin
            rand_inputs();
            #1;
            e = model_out();
            n_checks++;
            if (obs !== e) $display("FAIL routing frame %0d vec %0d: got %h expected %h", f, v, obs, e);
            else n_pass++;
         end
      end
   endtask

`ifdef LEFT_IO_TILE_SHADOW_EN
   task automatic test_shadow();
      logic [OW-1:0] e;
      do_reset();
      rand_inputs();
      load_frame(rand_frame());
      for (int j = 0; j < CL; j++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
         e = model_out();
         n_checks++;
         if (obs !== e) $display("FAIL shadow_hold shift %0d: got %h expected %h", j, obs, e);
         else n_pass++;
      end
      step(1'b0, 1'b0, 1'b1);
      e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL shadow_commit: got %h expected %h", obs, e);
      else n_pass++;
      step(1'b1, 1'b1, 1'b1);
      e = model_out();
      n_checks++;
      if (obs !== e) $display("FAIL shadow_simul: got %h expected %h", obs, e);
      else n_pass++;
   endtask
`endif

   initial begin
      ccff_head = 1'b0; ccff_en = 1'b0; ccff_commit = 1'b0;
      prog_reset = 1'b1; isol_n = 1'b1;
      chany_top_in = '0; chany_bottom_in = '0; chanx_right_in = '0;
      right_opin = '0; pad_in = '0;
      model_clear();
      test_reset();
      test_chain_latency();
      test_enable_gating();
      test_mux_pad();
      test_mid_frame_reset();
      test_random_routing();
`ifdef LEFT_IO_TILE_SHADOW_EN
      test_shadow();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
